// File: rtl/clock_time_counter_if.sv
// clock_time_counter_if: the tick, load, mode and status signals between the
// prescaler/controller (master) and the time-of-day counter core (slave).
// With CLOCK_TIME_ALARM_EN defined, the alarm compare inputs, the arm/ack
// controls and the sticky alarm output are added.
interface clock_time_counter_if #(
    parameter int W = 6
);
    // Controls from the prescaler / host
    logic         tick;
    logic         hold;
    logic         load;
    logic [W-1:0] hour_set;
    logic [W-1:0] minute_set;
    logic [W-1:0] second_set;
    logic         mode_12h;

    // Status towards the display / BCD encoder
    logic [W-1:0] hour;
    logic [W-1:0] minute;
    logic [W-1:0] second;
    logic         pm;
    logic         min_wrap;
    logic         hour_wrap;
    logic         day_wrap;
    logic         load_err;

`ifdef CLOCK_TIME_ALARM_EN
    // Alarm compare time (24-hour) and controls
    logic [W-1:0] alarm_hour;
    logic [W-1:0] alarm_minute;
    logic         alarm_arm;
    logic         alarm_ack;
    logic         alarm;

    modport master (
        output tick, hold, load, hour_set, minute_set, second_set, mode_12h,
        output alarm_hour, alarm_minute, alarm_arm, alarm_ack,
        input  hour, minute, second, pm, min_wrap, hour_wrap, day_wrap, load_err,
        input  alarm
    );

    modport slave (
        input  tick, hold, load, hour_set, minute_set, second_set, mode_12h,
        input  alarm_hour, alarm_minute, alarm_arm, alarm_ack,
        output hour, minute, second, pm, min_wrap, hour_wrap, day_wrap, load_err,
        output alarm
    );
`else
    modport master (
        output tick, hold, load, hour_set, minute_set, second_set, mode_12h,
        input  hour, minute, second, pm, min_wrap, hour_wrap, day_wrap, load_err
    );

    modport slave (
        input  tick, hold, load, hour_set, minute_set, second_set, mode_12h,
        output hour, minute, second, pm, min_wrap, hour_wrap, day_wrap, load_err
    );
`endif
endinterface

// File: rtl/clock_time_counter.sv
// clock_time_counter: parametrised hh:mm:ss time-of-day counter.
// Runs on clk and advances one second per cycle in which tick is high and
// hold is low. A synchronous load has priority over a tick, and each loaded
// field is range-checked on its own (out-of-range fields load as 0 and raise
// a one-cycle load_err). Rollover strobes are registered and coincide with
// the new count. The displayed hour is remapped combinationally for 12-hour
// mode; the internal count is always 24-hour.
// Optional build macro: CLOCK_TIME_ALARM_EN adds a sticky, armable alarm on
// hour:minute:00 reached by an advance.
module clock_time_counter #(
    parameter int W        = 6,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_time_counter_if.slave  ctc
);

    // Terminal values in the field width so all compares are W-bit
    localparam logic [W-1:0] SEC_MAX_W  = W'(SEC_MAX);
    localparam logic [W-1:0] MIN_MAX_W  = W'(MIN_MAX);
    localparam logic [W-1:0] HOUR_MAX_W = W'(HOUR_MAX);
    localparam logic [W-1:0] NOON_W     = W'(12);
    localparam logic [W-1:0] ONE_W      = W'(1);

    // Field index used by the load range checks: 0 = second, 1 = minute, 2 = hour
    localparam int NUM_FIELDS = 3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0] hour_q,   hour_d;
    logic [W-1:0] minute_q, minute_d;
    logic [W-1:0] second_q, second_d;
    logic         pm_q,        pm_d;
    logic         min_wrap_q,  min_wrap_d;
    logic         hour_wrap_q, hour_wrap_d;
    logic         day_wrap_q,  day_wrap_d;
    logic         load_err_q,  load_err_d;

    // An advance only happens when no load is present in the same cycle
    logic advance;
    assign advance = ctc.tick && !ctc.hold && !ctc.load;

    // ------------------------------------------------------------------
    // Load range checks, one identical slice per field
    // ------------------------------------------------------------------
    logic [W-1:0]          set_val  [NUM_FIELDS];
    logic [W-1:0]          load_val [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] field_bad;

    assign set_val[0] = ctc.second_set;
    assign set_val[1] = ctc.minute_set;
    assign set_val[2] = ctc.hour_set;

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field_chk
            localparam logic [W-1:0] FIELD_MAX = (gi == 0) ? SEC_MAX_W :
                                                 (gi == 1) ? MIN_MAX_W : HOUR_MAX_W;
            // An out-of-range field is forced to 0 rather than clipped
            assign field_bad[gi] = (set_val[gi] > FIELD_MAX);
            assign load_val[gi]  = field_bad[gi] ? '0 : set_val[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state: load, else cascaded advance, else hold the count
    // ------------------------------------------------------------------
    always_comb begin
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        min_wrap_d  = 1'b0;
        hour_wrap_d = 1'b0;
        day_wrap_d  = 1'b0;
        load_err_d  = 1'b0;

        if (ctc.load) begin
            second_d   = load_val[0];
            minute_d   = load_val[1];
            hour_d     = load_val[2];
            load_err_d = |field_bad;
        end else if (advance) begin
            if (second_q < SEC_MAX_W) begin
                second_d = second_q + ONE_W;
            end else begin
                second_d   = '0;
                min_wrap_d = 1'b1;
                if (minute_q < MIN_MAX_W) begin
                    minute_d = minute_q + ONE_W;
                end else begin
                    minute_d    = '0;
                    hour_wrap_d = 1'b1;
                    if (hour_q < HOUR_MAX_W) begin
                        hour_d = hour_q + ONE_W;
                    end else begin
                        hour_d     = '0;
                        day_wrap_d = 1'b1;
                    end
                end
            end
        end

        // pm tracks the next internal hour so it is registered with the count
        pm_d = (hour_d >= NOON_W);
    end

    // Count and strobe registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q      <= '0;
            minute_q    <= '0;
            second_q    <= '0;
            pm_q        <= 1'b0;
            min_wrap_q  <= 1'b0;
            hour_wrap_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            pm_q        <= pm_d;
            min_wrap_q  <= min_wrap_d;
            hour_wrap_q <= hour_wrap_d;
            day_wrap_q  <= day_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Display hour: 24-hour passthrough or 12-hour remap, no added latency
    // ------------------------------------------------------------------
    logic [W-1:0] hour_disp;

    // 0 shows as 12, 13..23 fold down by 12, 1..12 pass through
    always_comb begin
        hour_disp = hour_q;
        if (ctc.mode_12h) begin
            if (hour_q == '0) begin
                hour_disp = NOON_W;
            end else if (hour_q > NOON_W) begin
                hour_disp = hour_q - NOON_W;
            end
        end
    end

    assign ctc.hour      = hour_disp;
    assign ctc.minute    = minute_q;
    assign ctc.second    = second_q;
    assign ctc.pm        = pm_q;
    assign ctc.min_wrap  = min_wrap_q;
    assign ctc.hour_wrap = hour_wrap_q;
    assign ctc.day_wrap  = day_wrap_q;
    assign ctc.load_err  = load_err_q;

`ifdef CLOCK_TIME_ALARM_EN
    // ------------------------------------------------------------------
    // Alarm: sticky flag set when an advance lands on hh:mm:00
    // ------------------------------------------------------------------
    logic alarm_q, alarm_d;
    logic alarm_hit;

    // Compare against the next count so the flag rises with the new time;
    // a load never counts as reaching the alarm time
    assign alarm_hit = advance
                    && (hour_d   == ctc.alarm_hour)
                    && (minute_d == ctc.alarm_minute)
                    && (second_d == '0);

    // Disarm and acknowledge both clear, and win over a same-cycle hit
    always_comb begin
        alarm_d = alarm_q;
        if (!ctc.alarm_arm || ctc.alarm_ack) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end
    end

    // Alarm flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign ctc.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed checks of reset, cascade rollover, load
// range checking, hold, back-to-back ticks and 12-hour display mapping, plus
// the alarm when built with CLOCK_TIME_ALARM_EN.
module tb_clock_time_counter;

    localparam int W = 6;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    clock_time_counter_if #(.W(W)) dut_if ();

    clock_time_counter #(
        .W        (W),
        .SEC_MAX  (59),
        .MIN_MAX  (59),
        .HOUR_MAX (23)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctc (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the sequence is a fixed number of cycles
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s, input bit with_tick);
        dut_if.load       = 1'b1;
        dut_if.hour_set   = W'(h);
        dut_if.minute_set = W'(m);
        dut_if.second_set = W'(s);
        dut_if.tick       = with_tick;
        $display("[TB] load %0d:%0d:%0d tick=%0d", h, m, s, with_tick);
        step();
        dut_if.load = 1'b0;
        dut_if.tick = 1'b0;
    endtask

    task automatic do_tick();
        dut_if.tick = 1'b1;
        $display("[TB] tick");
        step();
        dut_if.tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*W-1:0] t;
        logic [4:0]     f;
        step();
        t = {dut_if.hour, dut_if.minute, dut_if.second};
        f = {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err};
        n_tests++;
        if (t !== '0) begin
            n_fail++;
            $display("FAIL reset_init_time: got %0d:%0d:%0d want 0:0:0", dut_if.hour, dut_if.minute, dut_if.second);
        end
        n_tests++;
        if (f !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_init_flags: got %b want 00000", f);
        end
        rst = 1'b0;
        do_load(13, 20, 30, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.pm} !== {6'd13, 6'd20, 6'd30, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_preload: got %0d:%0d:%0d pm=%0d want 13:20:30 pm=1",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.pm);
        end
        // Assert reset mid-cycle: outputs must clear without a clock edge
        #3;
        rst = 1'b1;
        $display("[TB] async reset");
        #1;
        t = {dut_if.hour, dut_if.minute, dut_if.second};
        f = {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err};
        n_tests++;
        if (t !== '0) begin
            n_fail++;
            $display("FAIL reset_async_time: got %0d:%0d:%0d want 0:0:0", dut_if.hour, dut_if.minute, dut_if.second);
        end
        n_tests++;
        if (f !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_async_flags: got %b want 00000", f);
        end
        dut_if.mode_12h = 1'b1;
        #1;
        n_tests++;
        if (dut_if.hour !== 6'd12) begin
            n_fail++;
            $display("FAIL reset_12h_hour: got %0d want 12", dut_if.hour);
        end
        dut_if.mode_12h = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_cascade();
        do_load(23, 59, 58, 1'b0);
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== {6'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL cascade_t1: got %0d:%0d:%0d want 23:59:59", dut_if.hour, dut_if.minute, dut_if.second);
        end
        n_tests++;
        if ({dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL cascade_f1: got %b want 10000",
                     {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err});
        end
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== '0) begin
            n_fail++;
            $display("FAIL cascade_t2: got %0d:%0d:%0d want 0:0:0", dut_if.hour, dut_if.minute, dut_if.second);
        end
        n_tests++;
        if ({dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err} !== 5'b01110) begin
            n_fail++;
            $display("FAIL cascade_f2: got %b want 01110",
                     {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err});
        end
        step();
        n_tests++;
        if ({dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL cascade_f3: got %b want 00000",
                     {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err});
        end
        // Minute rollover only, then hour rollover without day wrap
        do_load(5, 0, 59, 1'b0);
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap}
                !== {6'd5, 6'd1, 6'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL cascade_min: got %0d:%0d:%0d wraps=%b want 5:1:0 wraps=100", dut_if.hour, dut_if.minute,
                     dut_if.second, {dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap});
        end
        do_load(9, 59, 59, 1'b0);
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap}
                !== {6'd10, 6'd0, 6'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL cascade_hour: got %0d:%0d:%0d wraps=%b want 10:0:0 wraps=110", dut_if.hour, dut_if.minute,
                     dut_if.second, {dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap});
        end
    endtask

    task automatic test_load();
        do_load(24, 60, 5, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.load_err} !== {6'd0, 6'd0, 6'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL load_range: got %0d:%0d:%0d err=%0d want 0:0:5 err=1",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.load_err);
        end
        step();
        n_tests++;
        if (dut_if.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_err_pulse: got %0d want 0", dut_if.load_err);
        end
        do_load(11, 61, 62, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.load_err} !== {6'd11, 6'd0, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_fields: got %0d:%0d:%0d err=%0d want 11:0:0 err=1",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.load_err);
        end
        do_load(12, 0, 0, 1'b1);
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== {6'd12, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL load_tick_drop: got %0d:%0d:%0d want 12:0:0", dut_if.hour, dut_if.minute, dut_if.second);
        end
        n_tests++;
        if ({dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL load_tick_flags: got %b want 10000",
                     {dut_if.pm, dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap, dut_if.load_err});
        end
        // Loading 23:59:59 must not produce any wrap strobe
        do_load(0, 0, 0, 1'b0);
        do_load(23, 59, 59, 1'b0);
        n_tests++;
        if ({dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_no_wrap: got %b want 000", {dut_if.min_wrap, dut_if.hour_wrap, dut_if.day_wrap});
        end
    endtask

    task automatic test_hold();
        do_load(1, 2, 3, 1'b0);
        dut_if.hold = 1'b1;
        dut_if.tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            $display("[TB] held tick %0d", i);
            step();
            n_tests++;
            if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.min_wrap} !== {6'd1, 6'd2, 6'd3, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_%0d: got %0d:%0d:%0d want 1:2:3", i, dut_if.hour, dut_if.minute, dut_if.second);
            end
        end
        dut_if.hold = 1'b0;
        dut_if.tick = 1'b0;
        step();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== {6'd1, 6'd2, 6'd3}) begin
            n_fail++;
            $display("FAIL hold_no_replay: got %0d:%0d:%0d want 1:2:3", dut_if.hour, dut_if.minute, dut_if.second);
        end
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== {6'd1, 6'd2, 6'd4}) begin
            n_fail++;
            $display("FAIL hold_release: got %0d:%0d:%0d want 1:2:4", dut_if.hour, dut_if.minute, dut_if.second);
        end
    endtask

    task automatic test_back_to_back();
        do_load(0, 0, 58, 1'b0);
        dut_if.tick = 1'b1;
        $display("[TB] tick held for 3 cycles");
        repeat (3) step();
        dut_if.tick = 1'b0;
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.min_wrap} !== {6'd0, 6'd1, 6'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d:%0d:%0d mw=%0d want 0:1:1 mw=0",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.min_wrap);
        end
    endtask

    task automatic test_12h();
        dut_if.mode_12h = 1'b1;
        do_load(0, 0, 0, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.pm} !== {6'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL h12_midnight: got %0d pm=%0d want 12 pm=0", dut_if.hour, dut_if.pm);
        end
        do_load(12, 0, 0, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.pm} !== {6'd12, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_noon: got %0d pm=%0d want 12 pm=1", dut_if.hour, dut_if.pm);
        end
        do_load(11, 0, 0, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.pm} !== {6'd11, 1'b0}) begin
            n_fail++;
            $display("FAIL h12_11am: got %0d pm=%0d want 11 pm=0", dut_if.hour, dut_if.pm);
        end
        do_load(23, 0, 0, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.pm} !== {6'd11, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_11pm: got %0d pm=%0d want 11 pm=1", dut_if.hour, dut_if.pm);
        end
        do_load(13, 5, 0, 1'b0);
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.pm} !== {6'd1, 6'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_1pm: got %0d:%0d pm=%0d want 1:5 pm=1", dut_if.hour, dut_if.minute, dut_if.pm);
        end
        dut_if.mode_12h = 1'b0;
        $display("[TB] mode_12h -> 0");
        #1;
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second} !== {6'd13, 6'd5, 6'd0}) begin
            n_fail++;
            $display("FAIL h12_to_24: got %0d:%0d:%0d want 13:5:0", dut_if.hour, dut_if.minute, dut_if.second);
        end
        dut_if.mode_12h = 1'b1;
        $display("[TB] mode_12h -> 1");
        step();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.pm} !== {6'd1, 6'd5, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_back: got %0d:%0d:%0d pm=%0d want 1:5:0 pm=1",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.pm);
        end
        dut_if.mode_12h = 1'b0;
    endtask

`ifdef CLOCK_TIME_ALARM_EN
    task automatic test_alarm();
        dut_if.alarm_hour   = 6'd7;
        dut_if.alarm_minute = 6'd30;
        dut_if.alarm_arm    = 1'b1;
        do_load(7, 29, 59, 1'b0);
        n_tests++;
        if (dut_if.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_pre: got %0d want 0", dut_if.alarm);
        end
        do_tick();
        n_tests++;
        if ({dut_if.hour, dut_if.minute, dut_if.second, dut_if.alarm} !== {6'd7, 6'd30, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL alarm_fire: got %0d:%0d:%0d alarm=%0d want 7:30:0 alarm=1",
                     dut_if.hour, dut_if.minute, dut_if.second, dut_if.alarm);
        end
        step();
        step();
        n_tests++;
        if (dut_if.alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_sticky: got %0d want 1", dut_if.alarm);
        end
        dut_if.alarm_ack = 1'b1;
        $display("[TB] alarm_ack");
        step();
        dut_if.alarm_ack = 1'b0;
        n_tests++;
        if (dut_if.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_ack: got %0d want 0", dut_if.alarm);
        end
        do_load(7, 30, 0, 1'b0);
        n_tests++;
        if (dut_if.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_load: got %0d want 0", dut_if.alarm);
        end
        do_load(7, 29, 59, 1'b0);
        do_tick();
        dut_if.alarm_arm = 1'b0;
        $display("[TB] alarm_arm -> 0");
        step();
        n_tests++;
        if (dut_if.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_disarm: got %0d want 0", dut_if.alarm);
        end
    endtask
`endif

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst               = 1'b1;
        dut_if.tick       = 1'b0;
        dut_if.hold       = 1'b0;
        dut_if.load       = 1'b0;
        dut_if.hour_set   = '0;
        dut_if.minute_set = '0;
        dut_if.second_set = '0;
        dut_if.mode_12h   = 1'b0;
`ifdef CLOCK_TIME_ALARM_EN
        dut_if.alarm_hour   = '0;
        dut_if.alarm_minute = '0;
        dut_if.alarm_arm    = 1'b0;
        dut_if.alarm_ack    = 1'b0;
`endif
        test_reset();
        test_cascade();
        test_load();
        test_hold();
        test_back_to_back();
        test_12h();
`ifdef CLOCK_TIME_ALARM_EN
        test_alarm();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
